// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, receiver state type and frame check
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BIT_START  = 0;
  localparam int BIT_PARITY = 9;
  localparam int BIT_STOP   = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  // A frame is good when start is low, stop is high and data+parity has odd weight.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[BIT_START] == 1'b0) && f[BIT_STOP] && (^f[BIT_PARITY:1]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop on an empty FIFO is ignored; a push while full only lands if a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Show-ahead head reads as zero while empty so reset presents 0x00.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage write; when full with a simultaneous pop this overwrites the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver feeding a byte FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rdn,
  input  logic                        clr_err,
  output logic [7:0]                  data,
  output logic                        ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int TW = $clog2(TIMEOUT+1);

  logic [2:0]            clk_sync;
  logic [2:0]            data_sync;
  logic                  fall;
  logic                  bit_in;

  rx_state_t             state;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         idle_cnt;
  logic [BIT_PARITY:0]   shreg;
  logic [FRAME_BITS-1:0] frame_now;
  logic                  push_req;
  logic [7:0]            push_byte;
  logic                  bad;

  logic                  full;
  logic                  empty;
  logic                  pop;

  // Bit 0 is the first flop after the pin; edge detect looks at stages 1 and 2.
  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // The frame as it will look once the current (stop) bit is captured.
  assign frame_now = {bit_in, shreg};

  // Pin synchronisers; reset to 1 so the bus looks idle and no false edge appears.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  // Receiver FSM: collects 11 bits, checks the frame, and aborts stalled partial frames.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shreg     <= '0;
      push_req  <= 1'b0;
      push_byte <= '0;
      bad       <= 1'b0;
    end else begin
      push_req <= 1'b0;
      bad      <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall) begin
            shreg[BIT_START] <= bit_in;
            bit_cnt          <= 4'd1;
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'(BIT_STOP)) begin
              state   <= IDLE;
              bit_cnt <= '0;
              if (frame_ok(frame_now)) begin
                push_req  <= 1'b1;
                push_byte <= frame_now[8:1];
              end else begin
                bad <= 1'b1;
              end
            end else begin
              shreg[bit_cnt] <= bit_in;
              bit_cnt        <= bit_cnt + 4'd1;
            end
          end else if (idle_cnt == TW'(TIMEOUT-1)) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            bad      <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  assign ready = ~empty;
  assign pop   = ~rdn & ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push_req),
    .wdata (push_byte),
    .pop   (~rdn),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (data)
  );

  // Sticky error flags; a set event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (push_req & full & ~pop) | (overflow & ~clr_err);
      frame_err <= bad | (frame_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic p_clk = 1'b1;
  logic p_data = 1'b1;
  logic sel = 1'b0;
  logic rdn = 1'b1;
  logic clr_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int half = 10;
  logic [7:0] exp_q [$];

  logic       a_ps2_clk, a_ps2_data, b_ps2_clk, b_ps2_data;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, a_ovf, b_ovf, a_ferr, b_ferr;
  logic [4:0] a_count;
  logic [2:0] b_count;

  logic [7:0] cur_data, cur_count;
  logic       cur_ready, cur_ovf, cur_ferr;

  always #5 clk = ~clk;

  assign a_ps2_clk  = sel ? 1'b1 : p_clk;
  assign a_ps2_data = sel ? 1'b1 : p_data;
  assign b_ps2_clk  = sel ? p_clk  : 1'b1;
  assign b_ps2_data = sel ? p_data : 1'b1;

  assign cur_data  = sel ? b_data  : a_data;
  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_count = sel ? {5'd0, b_count} : {3'd0, a_count};
  assign cur_ovf   = sel ? b_ovf   : a_ovf;
  assign cur_ferr  = sel ? b_ferr  : a_ferr;

  ps2_rx_fifo dut_a (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (a_ps2_clk),
    .ps2_data  (a_ps2_data),
    .rdn       (rdn),
    .clr_err   (clr_err),
    .data      (a_data),
    .ready     (a_ready),
    .count     (a_count),
    .overflow  (a_ovf),
    .frame_err (a_ferr)
  );

  ps2_rx_fifo #(.DEPTH(4), .TIMEOUT(50)) dut_b (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (b_ps2_clk),
    .ps2_data  (b_ps2_data),
    .rdn       (rdn),
    .clr_err   (clr_err),
    .data      (b_data),
    .ready     (b_ready),
    .count     (b_count),
    .overflow  (b_ovf),
    .frame_err (b_ferr)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      p_data = f[i];
      cycles(half);
      p_clk = 1'b0;
      cycles(half);
      p_clk = 1'b1;
    end
  endtask

  // Leaves the stop-bit falling edge driven just after a posedge.
  task automatic stop_fall(input logic [10:0] f);
    p_data = f[10];
    cycles(half);
    p_clk = 1'b0;
  endtask

  task automatic stop_rise();
    cycles(half);
    p_clk = 1'b1;
    cycles(4);
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 10);
    stop_fall(f);
    stop_rise();
  endtask

  task automatic read_one(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      e = 8'h00;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_ready"}, {7'd0, cur_ready}, 8'd1);
    check({tag, "_data"}, cur_data, e);
    rdn = 1'b0;
    cycles(1);
    rdn = 1'b1;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0;
    cycles(3);
    clrn = 1'b1;
    cycles(2);

    // Reset state of both instances.
    check("rst_a_ready", {7'd0, a_ready}, 8'd0);
    check("rst_a_count", {3'd0, a_count}, 8'd0);
    check("rst_a_data", a_data, 8'h00);
    check("rst_a_ovf", {7'd0, a_ovf}, 8'd0);
    check("rst_a_ferr", {7'd0, a_ferr}, 8'd0);
    check("rst_b_ready", {7'd0, b_ready}, 8'd0);
    check("rst_b_count", {5'd0, b_count}, 8'd0);
    check("rst_b_data", b_data, 8'h00);

    // Default instance, slow PS/2 clock, exact push latency.
    sel = 1'b0;
    half = 500;
    send_bits(mk(8'h1C, 1'b0), 10);
    stop_fall(mk(8'h1C, 1'b0));
    cycles(3);
    check("lat_ready_early", {7'd0, cur_ready}, 8'd0);
    cycles(1);
    check("lat_ready", {7'd0, cur_ready}, 8'd1);
    check("lat_data", cur_data, 8'h1C);
    check("lat_count", cur_count, 8'd1);
    stop_rise();
    rdn = 1'b0;
    cycles(1);
    rdn = 1'b1;
    check("pop_ready", {7'd0, cur_ready}, 8'd0);
    check("pop_count", cur_count, 8'd0);

    // Bad parity is discarded and flagged.
    sel = 1'b1;
    half = 10;
    cycles(5);
    send_frame(mk(8'h1C, 1'b1));
    check("par_count", cur_count, 8'd0);
    check("par_ready", {7'd0, cur_ready}, 8'd0);
    check("par_ferr", {7'd0, cur_ferr}, 8'd1);
    clear_errors();
    check("par_ferr_clr", {7'd0, cur_ferr}, 8'd0);

    // Five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(mk(8'(i), 1'b0));
      if (i <= 4) exp_q.push_back(8'(i));
    end
    check("ovf_count", cur_count, 8'd4);
    check("ovf_flag", {7'd0, cur_ovf}, 8'd1);
    for (int i = 0; i < 4; i++) read_one("ovf_rd");
    check("ovf_empty", {7'd0, cur_ready}, 8'd0);
    clear_errors();
    check("ovf_clr", {7'd0, cur_ovf}, 8'd0);

    // Full FIFO, pop on the exact push cycle of the fifth byte.
    for (int i = 1; i <= 4; i++) begin
      send_frame(mk(8'(i), 1'b0));
      exp_q.push_back(8'(i));
    end
    send_bits(mk(8'h05, 1'b0), 10);
    stop_fall(mk(8'h05, 1'b0));
    cycles(3);
    check("sim_head", cur_data, exp_q[0]);
    rdn = 1'b0;
    cycles(1);
    rdn = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h05);
    stop_rise();
    check("sim_count", cur_count, 8'd4);
    check("sim_ovf", {7'd0, cur_ovf}, 8'd0);
    for (int i = 0; i < 4; i++) read_one("sim_rd");
    check("sim_empty", {7'd0, cur_ready}, 8'd0);

    // Stalled partial frame times out, next frame still lands.
    send_bits(mk(8'h33, 1'b0), 4);
    cycles(60);
    check("to_ferr", {7'd0, cur_ferr}, 8'd1);
    check("to_count0", cur_count, 8'd0);
    send_frame(mk(8'hF0, 1'b0));
    exp_q.push_back(8'hF0);
    check("to_count1", cur_count, 8'd1);
    read_one("to_rd");
    clear_errors();

    // Reset mid-frame discards the partial frame.
    send_bits(mk(8'hA5, 1'b0), 6);
    cycles(5);
    clrn = 1'b0;
    cycles(1);
    clrn = 1'b1;
    cycles(2);
    send_frame(mk(8'h5A, 1'b0));
    exp_q.push_back(8'h5A);
    check("mr_count", cur_count, 8'd1);
    check("mr_ferr", {7'd0, cur_ferr}, 8'd0);
    read_one("mr_rd");
    check("mr_empty", {7'd0, cur_ready}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
